// File: rtl/sd_in_ddr_if.sv
// srdy/drdy bus with a parameterised data width; the same interface carries the
// half-width DDR input side and the full-width SDR output side.
interface sd_in_ddr_if #(
   parameter int DW = 8
);
   logic          srdy;
   logic          drdy;
   logic [DW-1:0] data;

   modport master (output srdy, output data, input drdy);
   modport slave  (input srdy, input data, output drdy);
endinterface

// File: rtl/sd_in_ddr.sv
// DDR-to-SDR srdy/drdy input stage: reassembles half-width DDR words, 1-cycle latency.
// Backpressure absorbed by a 2-entry skid so c_drdy stays a flop; c_drdy drops only when full.
module sd_in_ddr #(
   parameter int width = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   sd_in_ddr_if.slave     c_if,
   sd_in_ddr_if.master    p_if
);
   localparam int HW = width / 2;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [HW-1:0]    hi_q;
   logic [width-1:0] out_q, out_d;
   logic [width-1:0] skid_q, skid_d;
   logic             c_drdy_q, c_drdy_d;
   logic [width-1:0] in_word;
   logic             accept;

   // Upper half is presented while clk is high, so it is captured on the falling edge.
   always_ff @(negedge clk) begin
      hi_q <= c_if.data;
   end

   assign in_word = {hi_q, c_if.data};
   assign accept  = c_if.srdy & c_drdy_q;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         S_EMPTY: begin
            if (accept) begin
               state_d = S_ONE;
               out_d   = in_word;
            end
         end
         S_ONE: begin
            if (accept && p_if.drdy) begin
               out_d = in_word;
            end else if (accept) begin
               state_d = S_FULL;
               skid_d  = in_word;
            end else if (p_if.drdy) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (p_if.drdy) begin
               state_d = S_ONE;
               out_d   = skid_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      c_drdy_d = (state_d != S_FULL) & reset_n;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_EMPTY;
         c_drdy_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         c_drdy_q <= c_drdy_d;
      end
   end

   // Data registers carry no reset; p_data is only meaningful while p_srdy is high.
   always_ff @(posedge clk) begin
      out_q  <= out_d;
      skid_q <= skid_d;
   end

   assign c_if.drdy = c_drdy_q;
   assign p_if.srdy = (state_q != S_EMPTY);
   assign p_if.data = out_q;
endmodule

// File: tb/tb_sd_in_ddr.sv
// Directed vector table plus a randomised scoreboard run for sd_in_ddr (width=8).
module tb_sd_in_ddr;
   logic clk;
   logic reset_n;

   sd_in_ddr_if #(.DW(4)) c_if ();
   sd_in_ddr_if #(.DW(8)) p_if ();

   sd_in_ddr #(.width(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .c_if    (c_if),
      .p_if    (p_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       cs;
      logic       pd;
      logic [7:0] w;
      logic       e_ps;
      logic       e_cd;
      logic       chk_d;
      logic [7:0] e_d;
   } vec_t;

   vec_t vt[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(logic rn, logic cs, logic pd, logic [7:0] w,
                               logic e_ps, logic e_cd, logic chk_d, logic [7:0] e_d);
      vec_t v;
      v.rst_n = rn; v.cs = cs; v.pd = pd; v.w = w;
      v.e_ps = e_ps; v.e_cd = e_cd; v.chk_d = chk_d; v.e_d = e_d;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called just after a rising edge: upper nibble in clk-high, lower nibble in clk-low.
   task automatic drive(input logic rn, input logic cs, input logic pd, input logic [7:0] w);
      reset_n   = rn;
      c_if.srdy = cs;
      p_if.drdy = pd;
      c_if.data = w[7:4];
      @(negedge clk);
      #1;
      c_if.data = w[3:0];
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] cur_w;
      logic [7:0] s_pd, prev_d, exp_w;
      logic       s_ps, s_cd, prev_hold, cs, pd;
      int         acc, cyc;

      reset_n   = 1'b0;
      c_if.srdy = 1'b0;
      c_if.data = 4'h0;
      p_if.drdy = 1'b0;

      // reset held 3 cycles, then release
      vt.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00));
      vt.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00));
      vt.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00));
      vt.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h00));
      // back-to-back stream with p_drdy high
      vt.push_back(mk(1, 1, 1, 8'hA5, 1, 1, 1, 8'hA5));
      vt.push_back(mk(1, 1, 1, 8'h3C, 1, 1, 1, 8'h3C));
      vt.push_back(mk(1, 1, 1, 8'hF0, 1, 1, 1, 8'hF0));
      vt.push_back(mk(1, 0, 1, 8'h00, 0, 1, 0, 8'h00));
      // fill skid, hold, then drain in order
      vt.push_back(mk(1, 1, 0, 8'h11, 1, 1, 1, 8'h11));
      vt.push_back(mk(1, 1, 0, 8'h22, 1, 0, 1, 8'h11));
      vt.push_back(mk(1, 1, 0, 8'h33, 1, 0, 1, 8'h11));
      vt.push_back(mk(1, 1, 0, 8'h33, 1, 0, 1, 8'h11));
      vt.push_back(mk(1, 1, 1, 8'h33, 1, 1, 1, 8'h22));
      vt.push_back(mk(1, 1, 1, 8'h33, 1, 1, 1, 8'h33));
      vt.push_back(mk(1, 0, 1, 8'h00, 0, 1, 0, 8'h00));
      // reset while full discards both words; 0x77 offered while c_drdy=0 is ignored
      vt.push_back(mk(1, 1, 0, 8'h44, 1, 1, 1, 8'h44));
      vt.push_back(mk(1, 1, 0, 8'h55, 1, 0, 1, 8'h44));
      vt.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00));
      vt.push_back(mk(1, 1, 0, 8'h77, 0, 1, 0, 8'h00));
      vt.push_back(mk(1, 1, 1, 8'h66, 1, 1, 1, 8'h66));
      vt.push_back(mk(1, 0, 1, 8'h00, 0, 1, 0, 8'h00));
      // nibble order
      vt.push_back(mk(1, 1, 0, 8'hF0, 1, 1, 1, 8'hF0));
      vt.push_back(mk(1, 1, 1, 8'h0F, 1, 1, 1, 8'h0F));
      vt.push_back(mk(1, 0, 1, 8'h00, 0, 1, 0, 8'h00));

      @(posedge clk);
      #1;
      foreach (vt[i]) begin
         drive(vt[i].rst_n, vt[i].cs, vt[i].pd, vt[i].w);
         chk($sformatf("vec%0d p_srdy", i), 32'(p_if.srdy), 32'(vt[i].e_ps));
         chk($sformatf("vec%0d c_drdy", i), 32'(c_if.drdy), 32'(vt[i].e_cd));
         if (vt[i].chk_d)
            chk($sformatf("vec%0d p_data", i), 32'(p_if.data), 32'(vt[i].e_d));
      end

      // random handshakes against a queue model of the two-entry buffer
      acc       = 0;
      cyc       = 0;
      prev_hold = 1'b0;
      prev_d    = 8'h00;
      cur_w     = 8'($urandom);
      while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
         s_ps = p_if.srdy;
         s_cd = c_if.drdy;
         s_pd = p_if.data;
         if (prev_hold)
            chk("rand stable", 32'(s_pd), 32'(prev_d));
         cs = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         pd = 1'($urandom_range(0, 1));
         drive(1'b1, cs, pd, cur_w);
         if (pd && s_ps) begin
            if (q.size() == 0) begin
               chk("rand spurious word", 32'(s_pd), 32'hFFFF_FFFF);
            end else begin
               exp_w = q.pop_front();
               chk("rand order", 32'(s_pd), 32'(exp_w));
            end
         end
         if (cs && s_cd) begin
            q.push_back(cur_w);
            acc++;
            cur_w = 8'($urandom);
         end
         chk("rand outstanding<=2", 32'(q.size() <= 2), 32'd1);
         chk("rand p_srdy", 32'(p_if.srdy), 32'(q.size() > 0));
         chk("rand c_drdy", 32'(c_if.drdy), 32'(q.size() < 2));
         prev_hold = s_ps && !pd;
         prev_d    = s_pd;
         cyc++;
      end
      chk("rand cycle budget", 32'(cyc < 20000), 32'd1);
      chk("rand words accepted", 32'(acc), 32'd1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
